// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample writer: channel codes, default ring layout, FSM states.
package adc_pkg;

  localparam logic CH_EMG = 1'b0;
  localparam logic CH_ECG = 1'b1;

  localparam logic [11:0] CH0_BASE_DEF  = 12'h400;
  localparam logic [11:0] CH1_BASE_DEF  = 12'h800;
  localparam int unsigned BUF_DEPTH_DEF = 640;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2
  } adc_state_e;

endpackage

// File: rtl/adc_sample_writer_ring_index.sv
// Per-channel circular write index with a sticky wrapped flag.
module ring_index #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             wrapped
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      wrapped <= 1'b0;
    end else if (clear) begin
      idx     <= '0;
      wrapped <= 1'b0;
    end else if (inc) begin
      if (idx == IDX_W'(DEPTH - 1)) begin
        idx     <= '0;
        wrapped <= 1'b1;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc_sample_writer.sv
// Paces ADC sampling, alternates EMG/ECG channels and writes samples into per-channel RAM rings.
module adc_sample_writer
  import adc_pkg::*;
#(
  parameter int unsigned       SAMPLE_INTERVAL = 175000,
  parameter int unsigned       CNT_W           = 18,
  parameter int unsigned       ADDR_W          = 12,
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       BUF_DEPTH       = BUF_DEPTH_DEF,
  parameter int unsigned       IDX_W           = 10,
  parameter logic [ADDR_W-1:0] CH0_BASE        = ADDR_W'(CH0_BASE_DEF),
  parameter logic [ADDR_W-1:0] CH1_BASE        = ADDR_W'(CH1_BASE_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic              ch0_valid,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic              ch1_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [IDX_W-1:0]  ch0_idx,
  output logic [IDX_W-1:0]  ch1_idx,
  output logic              ch0_wrapped,
  output logic              ch1_wrapped,
  output logic [15:0]       skip_count
);

  adc_state_e        state;
  logic              sel;
  logic [CNT_W-1:0]  count;
  logic              tick;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] sel_addr;
  logic              inc0;
  logic              inc1;

  assign tick = enable && (count == CNT_W'(SAMPLE_INTERVAL - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    sel_valid = ch0_valid;
    sel_data  = ch0_data;
    sel_addr  = CH0_BASE + ADDR_W'(ch0_idx);
    if (sel == CH_ECG) begin
      sel_valid = ch1_valid;
      sel_data  = ch1_data;
      sel_addr  = CH1_BASE + ADDR_W'(ch1_idx);
    end
  end

  // wr_en is raised on leaving CAPTURE so it is high exactly while in WRITE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= CH_EMG;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      skip_count <= '0;
    end else if (clear) begin
      state      <= IDLE;
      sel        <= CH_EMG;
      wr_en      <= 1'b0;
      skip_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) state <= CAPTURE;
        end
        CAPTURE: begin
          if (sel_valid) begin
            wr_data <= sel_data;
            wr_addr <= sel_addr;
            wr_en   <= 1'b1;
            state   <= WRITE;
          end else begin
            if (skip_count != '1) skip_count <= skip_count + 16'd1;
            sel   <= ~sel;
            state <= IDLE;
          end
        end
        WRITE: begin
          sel   <= ~sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign inc0 = (state == WRITE) && (sel == CH_EMG);
  assign inc1 = (state == WRITE) && (sel == CH_ECG);

  ring_index #(.DEPTH(BUF_DEPTH), .IDX_W(IDX_W)) u_ring_ch0 (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .inc     (inc0),
    .idx     (ch0_idx),
    .wrapped (ch0_wrapped)
  );

  ring_index #(.DEPTH(BUF_DEPTH), .IDX_W(IDX_W)) u_ring_ch1 (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .inc     (inc1),
    .idx     (ch1_idx),
    .wrapped (ch1_wrapped)
  );

endmodule
